// File: rtl/ps2_direction_decoder.sv
// PS/2 keyboard receiver that turns arrow/WASD make codes into a sticky 3-bit
// direction code, with Enter and frame-error strobes for the game master.
//
// state        | meaning
// RX_IDLE      | waiting for a start bit
// RX_SHIFT     | collecting 8 data bits, parity and stop
// RX_CHECK     | one cycle to validate the collected frame
// D_IDLE       | no prefix pending
// D_EXT        | E0 seen, next byte is an extended make or F0
// D_BREAK      | F0 seen, next byte is a released key
// D_EXT_BREAK  | E0 F0 seen, next byte is a released extended key
module ps2_direction_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [2:0] dir,
    output logic       dir_strobe,
    output logic       start_strobe,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BREAK, D_EXT_BREAK} dec_state_t;

    rx_state_t  rx_state;
    dec_state_t dec_state;

    logic          clk_s1, clk_s2, clk_s3;
    logic          dat_s1, dat_s2;
    logic [9:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;

    logic       fall;
    logic       frame_ok;
    logic       byte_valid;
    logic       err_now;
    logic [7:0] rx_byte;

    always_comb begin
        fall       = clk_s3 & ~clk_s2;
        rx_byte    = shreg[7:0];
        frame_ok   = (^shreg[8:0]) & shreg[9];
        byte_valid = (rx_state == RX_CHECK) && frame_ok;
        err_now    = 1'b0;
        if (rx_state == RX_IDLE && fall && dat_s2)
            err_now = 1'b1;
        if (rx_state == RX_CHECK && !frame_ok)
            err_now = 1'b1;
        if (rx_state == RX_SHIFT && !fall && to_cnt == TO_MAX)
            err_now = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_s1       <= 1'b1;
            clk_s2       <= 1'b1;
            clk_s3       <= 1'b1;
            dat_s1       <= 1'b1;
            dat_s2       <= 1'b1;
            rx_state     <= RX_IDLE;
            dec_state    <= D_IDLE;
            shreg        <= '0;
            bit_cnt      <= '0;
            to_cnt       <= '0;
            dir          <= 3'b000;
            dir_strobe   <= 1'b0;
            start_strobe <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_dat;
            dat_s2 <= dat_s1;

            dir_strobe   <= 1'b0;
            start_strobe <= 1'b0;
            frame_err    <= err_now;

            case (rx_state)
                RX_IDLE: begin
                    to_cnt <= '0;
                    if (fall && !dat_s2) begin
                        rx_state <= RX_SHIFT;
                        bit_cnt  <= '0;
                    end
                end
                RX_SHIFT: begin
                    if (fall) begin
                        to_cnt  <= '0;
                        shreg   <= {dat_s2, shreg[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9)
                            rx_state <= RX_CHECK;
                    end else if (to_cnt == TO_MAX) begin
                        to_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    to_cnt   <= '0;
                    rx_state <= RX_IDLE;
                end
            endcase

            // Decoding runs in the RX_CHECK cycle so outputs land one cycle later.
            if (err_now) begin
                dec_state <= D_IDLE;
            end else if (byte_valid) begin
                case (dec_state)
                    D_IDLE: begin
                        if (rx_byte == 8'hE0)
                            dec_state <= D_EXT;
                        else if (rx_byte == 8'hF0)
                            dec_state <= D_BREAK;
                        else begin
                            case (rx_byte)
                                8'h1D: begin dir <= 3'b001; dir_strobe <= 1'b1; end
                                8'h1B: begin dir <= 3'b010; dir_strobe <= 1'b1; end
                                8'h1C: begin dir <= 3'b011; dir_strobe <= 1'b1; end
                                8'h23: begin dir <= 3'b100; dir_strobe <= 1'b1; end
                                8'h5A: start_strobe <= 1'b1;
                                default: ;
                            endcase
                        end
                    end
                    D_EXT: begin
                        if (rx_byte == 8'hF0)
                            dec_state <= D_EXT_BREAK;
                        else begin
                            dec_state <= D_IDLE;
                            case (rx_byte)
                                8'h75: begin dir <= 3'b001; dir_strobe <= 1'b1; end
                                8'h72: begin dir <= 3'b010; dir_strobe <= 1'b1; end
                                8'h6B: begin dir <= 3'b011; dir_strobe <= 1'b1; end
                                8'h74: begin dir <= 3'b100; dir_strobe <= 1'b1; end
                                default: ;
                            endcase
                        end
                    end
                    default: dec_state <= D_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Scoreboard bench for ps2_direction_decoder: expected strobe events are queued
// as frames are sent and matched as the strobes appear.
module tb_ps2_direction_decoder;

    localparam int TO = 200;
    localparam int HALF = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [2:0] dir;
    logic       dir_strobe, start_strobe, frame_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_fall_cyc = 0;
    bit lat_check = 1'b0;

    // Event word: {frame_err, start_strobe, dir_strobe, dir}
    logic [5:0] exp_q[$];

    ps2_direction_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_dat(ps2_dat),
        .dir(dir),
        .dir_strobe(dir_strobe),
        .start_strobe(start_strobe),
        .frame_err(frame_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && (dir_strobe || start_strobe || frame_err)) begin
            if (exp_q.size() == 0)
                check_val("spurious_event", {26'd0, frame_err, start_strobe, dir_strobe, dir}, 32'd0);
            else
                check_val("event", {26'd0, frame_err, start_strobe, dir_strobe, dir},
                          {26'd0, exp_q.pop_front()});
            if (dir_strobe && lat_check) begin
                check_val("strobe_latency", cyc - last_fall_cyc, 4);
                lat_check = 1'b0;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            wait_cycles(HALF / 2);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
            wait_cycles(HALF / 2);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        logic par;
        par = bad_par ? (^b) : ~(^b);
        send_bits({1'b1, par, b, 1'b0}, 11);
        wait_cycles(30);
    endtask

    task automatic ev_dir(input logic [2:0] d);
        exp_q.push_back({3'b001, d});
    endtask

    task automatic ev_start(input logic [2:0] d);
        exp_q.push_back({3'b010, d});
    endtask

    task automatic ev_err(input logic [2:0] d);
        exp_q.push_back({3'b100, d});
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(2);
        check_val("reset_dir", dir, 0);
        check_val("reset_strobes", {dir_strobe, start_strobe, frame_err}, 0);

        // Extended up, with output latency measured from the stop-bit edge
        send_byte(8'hE0, 0);
        ev_dir(3'b001);
        lat_check = 1'b1;
        send_byte(8'h75, 0);
        check_val("ext_up_dir", dir, 3'b001);
        check_val("ext_up_latency_seen", lat_check, 0);

        // WASD left, right, then Enter
        ev_dir(3'b011);
        send_byte(8'h1C, 0);
        check_val("left_dir", dir, 3'b011);
        ev_dir(3'b100);
        send_byte(8'h23, 0);
        ev_start(3'b100);
        send_byte(8'h5A, 0);
        check_val("after_enter_dir", dir, 3'b100);

        // Extended break leaves direction alone
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h74, 0);
        check_val("break_dir", dir, 3'b100);
        ev_dir(3'b001);
        send_byte(8'h1D, 0);
        check_val("w_up_dir", dir, 3'b001);

        // Parity error after E0 discards the prefix; 72 then decodes unprefixed
        send_byte(8'hE0, 0);
        ev_err(3'b001);
        send_byte(8'h75, 1);
        send_byte(8'h72, 0);
        check_val("parity_dir", dir, 3'b001);

        // Bad start bit
        ev_err(3'b001);
        send_bits(11'h001, 1);
        wait_cycles(30);

        // Timeout after a partial frame, then a clean extended left
        ev_err(3'b001);
        send_bits({3'b000, 8'h6B} << 1, 4);
        wait_cycles(TO + 60);
        check_val("timeout_queue", exp_q.size(), 0);
        send_byte(8'hE0, 0);
        ev_dir(3'b011);
        send_byte(8'h6B, 0);
        check_val("timeout_recover_dir", dir, 3'b011);

        // Reset in the middle of a 1B frame
        send_bits({1'b1, ~(^8'h1B), 8'h1B, 1'b0}, 5);
        pulse_reset();
        wait_cycles(40);
        check_val("midreset_dir", dir, 0);
        ev_dir(3'b010);
        send_byte(8'h1B, 0);
        check_val("after_reset_dir", dir, 3'b010);

        wait_cycles(20);
        check_val("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
